gddr_tx_sync_ctrl: RTL and testbench
====================================

Name: gddr_tx_sync_ctrl

Overview:
- Start-up and retrain sequencer for the 4:1 DDR output gearboxes (ECLK/SCLK domains, ECLK edge-clock buffer, CLKDIV divider).
- After PLL lock it performs the required order: stop ECLK, release the divider reset, restart ECLK, release gearbox reset. This aligns the internal UPDATE toggle with SCLK on every lane.
- Runs on a free-running reference clock, never on ECLK/SCLK; one instance serves all gearboxes of a port.

Parameters:
- LOCK_WAIT, 16, consecutive clk cycles pll_lock must be high before sequencing starts (>=1)
- STOP_WAIT, 4, clk cycles held in each ECLK stop/div-release/start step (>=1)
- RST_WAIT, 8, clk cycles after gearbox reset release before ready (>=1)
- CNT_W, 8, timer width; must hold max(LOCK_WAIT, STOP_WAIT, RST_WAIT)

Ports:
- clk  input  1  free-running reference clock
- RSTB  input  1  reset, synchronous, active-high
- pll_lock  input  1  PLL lock; asynchronous, synchronised internally by two flops
- retrain  input  1  single-cycle request to re-run the sequence; honoured only in READY
- eclk_stop  output  1  to ECLK buffer stop input
- div_rst  output  1  to CLKDIV reset
- gear_rst  output  1  to all gearbox RST inputs
- ready  output  1  gearboxes aligned, data valid
- state  output  3  current FSM state (debug)

Behaviour:
- All outputs are registered.
- Reset values while RSTB is high: eclk_stop=0, div_rst=1, gear_rst=1, ready=0, state=WAIT_LOCK, timer=0.
- States and encodings: WAIT_LOCK=0, STOP=1, DIV_REL=2, START=3, GEAR_REL=4, READY=5. Codes 6 and 7 go to WAIT_LOCK.
- WAIT_LOCK: outputs at reset values; timer counts cycles with synced lock=1 and clears to 0 on any lock=0. When timer reaches LOCK_WAIT, go to STOP.
- STOP: eclk_stop=1, div_rst=1, gear_rst=1; hold STOP_WAIT cycles, then DIV_REL.
- DIV_REL: eclk_stop=1, div_rst=0; hold STOP_WAIT cycles, then START.
- START: eclk_stop=0, div_rst=0, gear_rst=1; hold STOP_WAIT cycles, then GEAR_REL.
- GEAR_REL: gear_rst=0; hold RST_WAIT cycles, then READY.
- READY: ready=1; stays until lock loss or retrain.
- Timer clears on every state entry; each timed state lasts exactly its parameter in cycles.
- Timing, counted from the first clk edge at which synced lock=1 (k=0), with L=LOCK_WAIT, S=STOP_WAIT, R=RST_WAIT:
  - eclk_stop rises after edge L
  - div_rst falls after edge L+S
  - eclk_stop falls after edge L+2S
  - gear_rst falls after edge L+3S
  - ready rises after edge L+3S+R
- Lock loss (synced lock=0) in any state other than WAIT_LOCK: next edge enters WAIT_LOCK with reset output values. Outputs never pass through an intermediate state.
- retrain in READY: next edge enters WAIT_LOCK (ready=0, div_rst=1, gear_rst=1). A new lock-stable count starts; no PLL relock is required.
- retrain outside READY is ignored (not queued).
- Simultaneous lock loss and retrain: lock loss wins; same destination.
- RSTB mid-sequence overrides everything on that edge. eclk_stop drops to 0 immediately, which restarts ECLK with div_rst and gear_rst asserted.
- Invariant: eclk_stop=1 only while div_rst or the gear reset is held. gear_rst=0 implies eclk_stop=0 and div_rst=0.

Optional Feature:
- Macro: GDDR_SYNC_DLL_EN.
- With the macro defined:
  - adds input dll_lock (1, asynchronous, two-flop synced) and output dll_freeze (1).
  - The WAIT_LOCK stability condition becomes pll_lock AND dll_lock.
  - dll_freeze=1 from STOP entry through the end of START; otherwise 0; reset value 0.
  - Loss of dll_lock is treated as lock loss.
- Without the macro: ports absent; behaviour exactly as above.

Decomposition:
- Package gddr_sync_pkg: state encodings, STATE_W=3, default constants for LOCK_WAIT/STOP_WAIT/RST_WAIT.
- One sub-module: gddr_lock_filter, the two-flop synchroniser plus consecutive-high counter producing lock_ok and lock_lost. Reused by the RX-side sequencer.

Test Plan:
- Defaults; RSTB for 3 cycles; pll_lock high at k=0 -> eclk_stop rises at 16, div_rst falls at 20, eclk_stop falls at 24, gear_rst falls at 28, ready=1 at 36.
- pll_lock glitches low for 1 cycle at k=10 -> lock counter restarts; eclk_stop rises 16 cycles after the glitch ends.
- pll_lock drops during DIV_REL (k=22) -> next cycle eclk_stop=0, div_rst=1, gear_rst=1; relock re-runs the full sequence with identical intervals.
- retrain pulse in READY -> ready=0, gear_rst=1 next cycle; ready returns 36 cycles later. retrain pulse during STOP -> no effect.
- RSTB asserted while in STOP -> eclk_stop=0, div_rst=1, gear_rst=1, state=0 on that edge.
- With GDDR_SYNC_DLL_EN, pll_lock high and dll_lock low -> stays in WAIT_LOCK. dll_lock rising -> dll_freeze high over k=16..27 inclusive, low at 28.

Source files
------------

// File: rtl/gddr_sync_pkg.sv
// Shared types and defaults for the GDDR gearbox start-up sequencers.
// States, state width, default wait constants and the per-state output map.
package gddr_sync_pkg;

  localparam int STATE_W     = 3;
  localparam int LOCK_WAIT_D = 16;
  localparam int STOP_WAIT_D = 4;
  localparam int RST_WAIT_D  = 8;
  localparam int CNT_W_D     = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STOP      = 3'd1,
    ST_DIV_REL   = 3'd2,
    ST_START     = 3'd3,
    ST_GEAR_REL  = 3'd4,
    ST_READY     = 3'd5
  } sync_state_t;

  // {eclk_stop, div_rst, gear_rst, ready} held while in state s
  function automatic logic [3:0] outs_of(input sync_state_t s);
    logic [3:0] o;
    o = 4'b0110;
    case (s)
      ST_STOP:     o = 4'b1110;
      ST_DIV_REL:  o = 4'b1010;
      ST_START:    o = 4'b0010;
      ST_GEAR_REL: o = 4'b0000;
      ST_READY:    o = 4'b0001;
      default:     o = 4'b0110;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gddr_tx_sync_ctrl_lock_filter.sv
// gddr_lock_filter: two-flop synchroniser per lock bit plus stable-high counter.
// Ports: clk, RSTB (sync, active-high), i_lock[N], i_clr, o_lock_ok, o_lock_lost.
module gddr_lock_filter #(
  parameter int N         = 1,
  parameter int LOCK_WAIT = 16,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         RSTB,
  input  logic [N-1:0] i_lock,
  input  logic         i_clr,
  output logic         o_lock_ok,
  output logic         o_lock_lost
);

  localparam logic [CNT_W-1:0] LW = CNT_W'(LOCK_WAIT);

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lock;
  logic             w_full;

  assign w_lock = &r_s2;
  assign w_full = (r_cnt == LW);

  always_ff @(posedge clk) begin
    if (RSTB) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_lock;
      r_s2 <= r_s1;
      if (!w_lock || i_clr)
        r_cnt <= '0;
      else if (!w_full)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lock_ok   = w_lock && w_full;
  assign o_lock_lost = !w_lock;

endmodule

// File: rtl/gddr_tx_sync_ctrl.sv
// ECLK/CLKDIV/gearbox reset sequencer for 4:1 DDR output gearboxes.
// Ports: clk, RSTB, pll_lock, retrain -> eclk_stop, div_rst, gear_rst,
// ready, state. Option GDDR_SYNC_DLL_EN adds dll_lock / dll_freeze.
module gddr_tx_sync_ctrl
  import gddr_sync_pkg::*;
#(
  parameter int LOCK_WAIT = LOCK_WAIT_D,
  parameter int STOP_WAIT = STOP_WAIT_D,
  parameter int RST_WAIT  = RST_WAIT_D,
  parameter int CNT_W     = CNT_W_D
) (
  input  logic               clk,
  input  logic               RSTB,
  input  logic               pll_lock,
  input  logic               retrain,
`ifdef GDDR_SYNC_DLL_EN
  input  logic               dll_lock,
  output logic               dll_freeze,
`endif
  output logic               eclk_stop,
  output logic               div_rst,
  output logic               gear_rst,
  output logic               ready,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STOP_WAIT - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RST_WAIT - 1);

`ifdef GDDR_SYNC_DLL_EN
  localparam int N_LK = 2;
  logic [1:0] w_lk_in;
  assign w_lk_in = {dll_lock, pll_lock};
`else
  localparam int N_LK = 1;
  logic [0:0] w_lk_in;
  assign w_lk_in = pll_lock;
`endif

  sync_state_t      r_state;
  sync_state_t      w_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_tmr;
  logic [3:0]       r_out;
  logic             w_ok;
  logic             w_lost;
  logic             w_clr;

  // Lock count only runs while the FSM stays in WAIT_LOCK, so a retrain
  // or a fresh lock always starts from zero.
  assign w_clr = (w_nxt != ST_WAIT_LOCK);

  gddr_lock_filter #(
    .N         (N_LK),
    .LOCK_WAIT (LOCK_WAIT),
    .CNT_W     (CNT_W)
  ) u_filt (
    .clk         (clk),
    .RSTB        (RSTB),
    .i_lock      (w_lk_in),
    .i_clr       (w_clr),
    .o_lock_ok   (w_ok),
    .o_lock_lost (w_lost)
  );

  always_comb begin
    w_nxt = r_state;
    w_tmr = '0;
    case (r_state)
      ST_WAIT_LOCK: if (w_ok) w_nxt = ST_STOP;
      ST_STOP:
        if (r_timer == S_LAST) w_nxt = ST_DIV_REL;
        else w_tmr = r_timer + 1'b1;
      ST_DIV_REL:
        if (r_timer == S_LAST) w_nxt = ST_START;
        else w_tmr = r_timer + 1'b1;
      ST_START:
        if (r_timer == S_LAST) w_nxt = ST_GEAR_REL;
        else w_tmr = r_timer + 1'b1;
      ST_GEAR_REL:
        if (r_timer == R_LAST) w_nxt = ST_READY;
        else w_tmr = r_timer + 1'b1;
      ST_READY: if (retrain) w_nxt = ST_WAIT_LOCK;
      default: w_nxt = ST_WAIT_LOCK;
    endcase
    // Lock loss beats retrain and any timed step.
    if (r_state != ST_WAIT_LOCK && w_lost) begin
      w_nxt = ST_WAIT_LOCK;
      w_tmr = '0;
    end
  end

  // Outputs come straight from the next state, so they change on the
  // same edge as the state and never glitch through a mid value.
  always_ff @(posedge clk) begin
    if (RSTB) begin
      r_state <= ST_WAIT_LOCK;
      r_timer <= '0;
      r_out   <= 4'b0110;
    end else begin
      r_state <= w_nxt;
      r_timer <= w_tmr;
      r_out   <= outs_of(w_nxt);
    end
  end

`ifdef GDDR_SYNC_DLL_EN
  logic r_frz;
  always_ff @(posedge clk) begin
    if (RSTB)
      r_frz <= 1'b0;
    else
      r_frz <= (w_nxt == ST_STOP) || (w_nxt == ST_DIV_REL) ||
               (w_nxt == ST_START);
  end
  assign dll_freeze = r_frz;
`endif

  assign eclk_stop = r_out[3];
  assign div_rst   = r_out[2];
  assign gear_rst  = r_out[1];
  assign ready     = r_out[0];
  assign state     = r_state;

endmodule

// File: tb/tb_gddr_tx_sync_ctrl.sv
// Directed bench for gddr_tx_sync_ctrl with default parameters.
// Edge n counts from the edge after pll_lock rises; synced lock k = n-3.
module tb_gddr_tx_sync_ctrl;

  logic       clk = 1'b0;
  logic       RSTB;
  logic       pll_lock;
  logic       retrain;
  logic       eclk_stop;
  logic       div_rst;
  logic       gear_rst;
  logic       ready;
  logic [2:0] state;
`ifdef GDDR_SYNC_DLL_EN
  logic       dll_lock;
  logic       dll_freeze;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gddr_tx_sync_ctrl dut (
    .clk       (clk),
    .RSTB      (RSTB),
    .pll_lock  (pll_lock),
    .retrain   (retrain),
`ifdef GDDR_SYNC_DLL_EN
    .dll_lock  (dll_lock),
    .dll_freeze(dll_freeze),
`endif
    .eclk_stop (eclk_stop),
    .div_rst   (div_rst),
    .gear_rst  (gear_rst),
    .ready     (ready),
    .state     (state)
  );

  logic [6:0] got;
  assign got = {state, eclk_stop, div_rst, gear_rst, ready};

  // Expected {state, eclk_stop, div_rst, gear_rst, ready} after edge k
  // of a clean run (L=16, S=4, R=8).
  function automatic logic [6:0] exp_vec(input int k);
    logic [2:0] st;
    logic es, dr, gr, rd;
    if (k < 16)      st = 3'd0;
    else if (k < 20) st = 3'd1;
    else if (k < 24) st = 3'd2;
    else if (k < 28) st = 3'd3;
    else if (k < 36) st = 3'd4;
    else             st = 3'd5;
    es = (k >= 16) && (k < 24);
    dr = (k < 20);
    gr = (k < 28);
    rd = (k >= 36);
    return {st, es, dr, gr, rd};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    RSTB = 1'b1;
    repeat (3) step();
    RSTB = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] e;
    e = 7'b000_0110;
    pll_lock = 1'b0;
    retrain  = 1'b0;
    do_reset();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", got, e);
    end
    step();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", got, e);
    end
  endtask

  task automatic test_sequence;
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      checks++;
      if (got !== exp_vec(n - 3)) begin
        errors++;
        $display("FAIL seq n=%0d got=%b exp=%b", n, got, exp_vec(n - 3));
      end
    end
  endtask

  // Synced low seen at edge 13 (k=10); fresh count starts at edge 14.
  task automatic test_glitch;
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    for (int n = 1; n <= 54; n++) begin
      step();
      pll_lock = (n == 10) ? 1'b0 : 1'b1;
      checks++;
      if (got !== exp_vec(n - 14)) begin
        errors++;
        $display("FAIL glitch n=%0d got=%b exp=%b", n, got, exp_vec(n - 14));
      end
    end
  endtask

  // Synced low seen at edge 25 (k=22, DIV_REL), then a full relock.
  task automatic test_lock_loss;
    logic [6:0] e;
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 22) pll_lock = 1'b0;
      e = (n == 25) ? 7'b000_0110 : exp_vec(n - 3);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL loss n=%0d got=%b exp=%b", n, got, e);
      end
    end
    repeat (3) step();
    pll_lock = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      checks++;
      if (got !== exp_vec(n - 3)) begin
        errors++;
        $display("FAIL relock n=%0d got=%b exp=%b", n, got, exp_vec(n - 3));
      end
    end
  endtask

  // Starts in READY; retrain at m=1 restarts, retrain at m=18 (STOP) ignored.
  task automatic test_retrain;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL retrain_pre ready=%b exp=1", ready);
    end
    for (int m = 1; m <= 40; m++) begin
      if (m == 1 || m == 18) retrain = 1'b1;
      step();
      retrain = 1'b0;
      checks++;
      if (got !== exp_vec(m - 1)) begin
        errors++;
        $display("FAIL retrain m=%0d got=%b exp=%b", m, got, exp_vec(m - 1));
      end
    end
  endtask

  task automatic test_rst_mid;
    logic [6:0] e;
    e = 7'b000_0110;
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    repeat (20) step();
    checks++;
    if (got !== exp_vec(17)) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b exp=%b", got, exp_vec(17));
    end
    RSTB = 1'b1;
    step();
    RSTB = 1'b0;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rst_mid got=%b exp=%b", got, e);
    end
  endtask

`ifdef GDDR_SYNC_DLL_EN
  task automatic test_dll;
    logic f;
    pll_lock = 1'b1;
    dll_lock = 1'b0;
    do_reset();
    repeat (30) step();
    checks++;
    if (state !== 3'd0 || dll_freeze !== 1'b0) begin
      errors++;
      $display("FAIL dll_wait state=%0d frz=%b exp=0/0", state, dll_freeze);
    end
    dll_lock = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      step();
      f = (n - 3 >= 16) && (n - 3 < 28);
      checks++;
      if (dll_freeze !== f || got !== exp_vec(n - 3)) begin
        errors++;
        $display("FAIL dll n=%0d frz=%b exp=%b got=%b exp=%b",
                 n, dll_freeze, f, got, exp_vec(n - 3));
      end
    end
  endtask
`endif

  initial begin
    RSTB     = 1'b1;
    pll_lock = 1'b0;
    retrain  = 1'b0;
`ifdef GDDR_SYNC_DLL_EN
    dll_lock = 1'b1;
`endif
    test_reset();
    test_sequence();
    test_glitch();
    test_lock_loss();
    test_retrain();
    test_rst_mid();
`ifdef GDDR_SYNC_DLL_EN
    test_dll();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
